mipi_csi_rx_packet_decoder: RTL and testbench

MIPI_CSI_RX_PACKET_DECODER -- requirements
Module: mipi_csi_rx_packet_decoder

---
 rtl/mipi_csi_rx_packet_decoder.sv | 187 ++++++++++++++++++
 tb/tb_mipi_csi_rx_packet_decoder.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mipi_csi_rx_packet_decoder.sv
// CSI-2 receive packet decoder: header/short-packet decode, long-packet payload framing.
// Optional CRC-16 footer check is built when MIPI_CSI_RX_DECODER_CRC_EN is defined.
module mipi_csi_rx_packet_decoder (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        data_valid_i,
  input  logic [31:0] data_i,
  output logic [31:0] packet_header_o,
  input  logic [15:0] packet_length_i,
  input  logic [1:0]  vc_id_i,
  input  logic [5:0]  data_type_i,
  input  logic        no_error_i,
  input  logic        corrected_error_i,
  input  logic        error_i,
  output logic [31:0] payload_data_o,
  output logic [3:0]  payload_byte_en_o,
  output logic        payload_valid_o,
  output logic        payload_last_o,
  output logic        frame_start_o,
  output logic        frame_end_o,
  output logic        line_start_o,
  output logic        line_end_o,
  output logic [1:0]  vc_id_o,
  output logic [5:0]  data_type_o,
  output logic        header_error_o,
  output logic        corrected_error_o,
  output logic        truncated_o,
  output logic        crc_error_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {IDLE, PAYLOAD, WAIT_EOT} state_t;

  state_t      state_reg, state_next;
  logic [16:0] cnt_reg, cnt_next;
  logic [31:0] payload_data_next, payload_mask;
  logic [3:0]  byte_en, short_pulse_next;
  logic [1:0]  vc_next;
  logic [5:0]  dt_next;
  logic        valid_next, last_next, herr_next, cerr_next, trunc_next;
  logic        unused_inputs;

  // The ECC status "no error" is implied by the other two flags.
  assign unused_inputs   = no_error_i;
  assign packet_header_o = data_i;
  assign busy_o          = (state_reg != IDLE);

  // cnt_reg counts payload plus footer bytes still due; byte gi is payload while more than gi+2 remain.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign byte_en[3-gi]                  = (cnt_reg > 17'(gi + 2));
      assign payload_mask[31-8*gi -: 8]     = {8{byte_en[3-gi]}};
    end
  endgenerate

  always_comb begin
    state_next        = state_reg;
    cnt_next          = cnt_reg;
    payload_data_next = 32'h0;
    valid_next        = 1'b0;
    last_next         = 1'b0;
    short_pulse_next  = 4'h0;
    herr_next         = 1'b0;
    cerr_next         = 1'b0;
    trunc_next        = 1'b0;
    vc_next           = vc_id_o;
    dt_next           = data_type_o;
    case (state_reg)
      IDLE: begin
        if (data_valid_i) begin
          if (error_i) begin
            herr_next  = 1'b1;
            state_next = WAIT_EOT;
          end else begin
            vc_next   = vc_id_i;
            dt_next   = data_type_i;
            cerr_next = corrected_error_i;
            if (data_type_i < 6'h10) begin
              short_pulse_next = {data_type_i == 6'h00, data_type_i == 6'h01,
                                  data_type_i == 6'h02, data_type_i == 6'h03};
              state_next       = WAIT_EOT;
            end else begin
              cnt_next   = {1'b0, packet_length_i} + 17'd2;
              state_next = PAYLOAD;
            end
          end
        end
      end
      PAYLOAD: begin
        if (data_valid_i) begin
          valid_next        = |byte_en;
          payload_data_next = data_i & payload_mask;
          last_next         = (cnt_reg > 17'd2) && (cnt_reg <= 17'd6);
          if (cnt_reg <= 17'd4) begin
            cnt_next   = 17'd0;
            state_next = WAIT_EOT;
          end else begin
            cnt_next = cnt_reg - 17'd4;
          end
        end else begin
          trunc_next = 1'b1;
          cnt_next   = 17'd0;
          state_next = IDLE;
        end
      end
      WAIT_EOT: if (!data_valid_i) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg         <= IDLE;
      cnt_reg           <= 17'd0;
      payload_data_o    <= 32'h0;
      payload_byte_en_o <= 4'h0;
      payload_valid_o   <= 1'b0;
      payload_last_o    <= 1'b0;
      {frame_start_o, frame_end_o, line_start_o, line_end_o} <= 4'h0;
      vc_id_o           <= 2'd0;
      data_type_o       <= 6'd0;
      header_error_o    <= 1'b0;
      corrected_error_o <= 1'b0;
      truncated_o       <= 1'b0;
    end else begin
      state_reg         <= state_next;
      cnt_reg           <= cnt_next;
      payload_data_o    <= payload_data_next;
      payload_byte_en_o <= valid_next ? byte_en : 4'h0;
      payload_valid_o   <= valid_next;
      payload_last_o    <= last_next;
      {frame_start_o, frame_end_o, line_start_o, line_end_o} <= short_pulse_next;
      vc_id_o           <= vc_next;
      data_type_o       <= dt_next;
      header_error_o    <= herr_next;
      corrected_error_o <= cerr_next;
      truncated_o       <= trunc_next;
    end
  end

`ifdef MIPI_CSI_RX_DECODER_CRC_EN
  logic [15:0]       crc_reg;
  logic [7:0]        foot_lo_reg;
  logic [4:0][15:0]  crc_stage;
  logic [4:0][7:0]   lo_sel, hi_sel;

  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = (r[0] ^ b[i]) ? ((r >> 1) ^ 16'h8408) : (r >> 1);
    return r;
  endfunction

  // Footer low byte may arrive one word before the high byte, hence foot_lo_reg.
  assign crc_stage[0] = crc_reg;
  assign lo_sel[0]    = foot_lo_reg;
  assign hi_sel[0]    = 8'h00;
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_crc
      assign crc_stage[gi+1] = byte_en[3-gi] ? crc_byte(crc_stage[gi], data_i[31-8*gi -: 8])
                                             : crc_stage[gi];
      assign lo_sel[gi+1]    = (cnt_reg == 17'(gi + 2)) ? data_i[31-8*gi -: 8] : lo_sel[gi];
      assign hi_sel[gi+1]    = (cnt_reg == 17'(gi + 1)) ? data_i[31-8*gi -: 8] : hi_sel[gi];
    end
  endgenerate

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      crc_reg     <= 16'h0;
      foot_lo_reg <= 8'h0;
      crc_error_o <= 1'b0;
    end else begin
      crc_error_o <= 1'b0;
      if (state_reg == IDLE && data_valid_i) crc_reg <= 16'hFFFF;
      if (state_reg == PAYLOAD && data_valid_i) begin
        crc_reg     <= crc_stage[4];
        foot_lo_reg <= lo_sel[4];
        if (cnt_reg <= 17'd4) crc_error_o <= ({hi_sel[4], lo_sel[4]} != crc_stage[4]);
      end
    end
  end
`else
  assign crc_error_o = 1'b0;
`endif

endmodule

// File: tb/tb_mipi_csi_rx_packet_decoder.sv
// Bench for mipi_csi_rx_packet_decoder: directed vector table, corner sequences and a
// randomized burst generator checked against a byte-level packet model.
module tb_mipi_csi_rx_packet_decoder;

`ifdef MIPI_CSI_RX_DECODER_CRC_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif
  localparam logic [54:0] ALL_MASK = {55{1'b1}};
  localparam logic [54:0] TBL_MASK = CRC_ON ? ~(55'd1 << 9) : ALL_MASK;

  logic clk = 1'b0, rst = 1'b1;
  logic data_valid_i = 1'b0, error_i = 1'b0, corrected_error_i = 1'b0;
  logic [31:0] data_i = 32'h0;
  logic [31:0] packet_header_o, payload_data_o;
  logic [15:0] packet_length_i;
  logic [1:0]  vc_id_i, vc_id_o;
  logic [5:0]  data_type_i, data_type_o;
  logic        no_error_i;
  logic [3:0]  payload_byte_en_o;
  logic payload_valid_o, payload_last_o, frame_start_o, frame_end_o, line_start_o, line_end_o;
  logic header_error_o, corrected_error_o, truncated_o, crc_error_o, busy_o;

  int total = 0, bad = 0;
  logic [1:0] exp_vc = 2'd0;
  logic [5:0] exp_dt = 6'd0;

  always #5 clk = ~clk;

  // Stand-in for the combinational ECC stage: fields decoded straight from the header word.
  assign vc_id_i         = packet_header_o[31:30];
  assign data_type_i     = packet_header_o[29:24];
  assign packet_length_i = {packet_header_o[15:8], packet_header_o[23:16]};
  assign no_error_i      = !error_i && !corrected_error_i;

  mipi_csi_rx_packet_decoder dut (
    .clk_i(clk), .rst_i(rst), .data_valid_i(data_valid_i), .data_i(data_i),
    .packet_header_o(packet_header_o), .packet_length_i(packet_length_i),
    .vc_id_i(vc_id_i), .data_type_i(data_type_i), .no_error_i(no_error_i),
    .corrected_error_i(corrected_error_i), .error_i(error_i),
    .payload_data_o(payload_data_o), .payload_byte_en_o(payload_byte_en_o),
    .payload_valid_o(payload_valid_o), .payload_last_o(payload_last_o),
    .frame_start_o(frame_start_o), .frame_end_o(frame_end_o),
    .line_start_o(line_start_o), .line_end_o(line_end_o),
    .vc_id_o(vc_id_o), .data_type_o(data_type_o),
    .header_error_o(header_error_o), .corrected_error_o(corrected_error_o),
    .truncated_o(truncated_o), .crc_error_o(crc_error_o), .busy_o(busy_o)
  );

  typedef struct {
    logic v; logic [31:0] d; logic e; logic c;
    logic [31:0] pd; logic [3:0] be; logic pv; logic last; logic [3:0] sp;
    logic herr; logic cerr; logic tr; logic busy; logic [1:0] vc; logic [5:0] dt;
  } vec_t;

  function automatic logic [54:0] pk(input logic [31:0] pd, input logic [3:0] be, input logic pv,
                                     input logic last, input logic [3:0] sp, input logic herr,
                                     input logic cerr, input logic tr, input logic crc,
                                     input logic busy, input logic [1:0] vc, input logic [5:0] dt);
    return {pd, be, pv, last, sp, herr, cerr, tr, crc, busy, vc, dt};
  endfunction

  function automatic logic [15:0] crc16(input logic [7:0] q[$]);
    logic [15:0] c = 16'hFFFF;
    foreach (q[j])
      for (int i = 0; i < 8; i++)
        c = (c[0] ^ q[j][i]) ? ((c >> 1) ^ 16'h8408) : (c >> 1);
    return c;
  endfunction

  task automatic check(input string name, input logic [54:0] exp, input logic [54:0] mask);
    logic [54:0] act;
    act = {payload_data_o, payload_byte_en_o, payload_valid_o, payload_last_o, frame_start_o,
           frame_end_o, line_start_o, line_end_o, header_error_o, corrected_error_o,
           truncated_o, crc_error_o, busy_o, vc_id_o, data_type_o};
    total++;
    if (((act ^ exp) & mask) != 55'd0) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Apply one word for one clock; outputs are sampled 1 time unit after the edge.
  task automatic drive(input logic v, input logic [31:0] d, input logic e, input logic c);
    data_valid_i = v; data_i = d; error_i = e; corrected_error_i = c;
    #1;
    total++;
    if (packet_header_o !== d) begin
      bad++;
      $display("FAIL header_passthru: got %h expected %h", packet_header_o, d);
    end
    @(posedge clk); #1;
  endtask

  task automatic run_random(input int idx);
    int kind, len, needed, nw, start, n;
    logic [15:0] len16, crc;
    logic [1:0] vc; logic [5:0] dt;
    logic err, cor, bad_crc, is_long, short_trunc;
    logic [7:0] bytes[$];
    logic [31:0] w, m; logic [3:0] be, sp;
    kind  = $urandom_range(0, 9);
    vc    = 2'($urandom);
    dt    = (kind >= 1 && kind <= 3) ? 6'($urandom_range(0, 15)) : 6'($urandom_range(16, 63));
    len16 = 16'($urandom_range(0, 20));
    len   = int'(len16);
    err   = (kind == 0);
    cor   = ($urandom_range(0, 3) == 0);
    is_long = !err && dt >= 6'h10;
    bad_crc = 1'b0; needed = 0; short_trunc = 1'b0;
    bytes.delete();
    if (is_long) begin
      for (int i = 0; i < len; i++) bytes.push_back(8'($urandom));
      crc = crc16(bytes);
      bytes.push_back(crc[7:0]);
      bytes.push_back(crc[15:8]);
      bad_crc = ($urandom_range(0, 2) == 0);
      if (bad_crc) bytes[len + $urandom_range(0, 1)] ^= 8'(1 << $urandom_range(0, 7));
      needed = (len + 5) / 4;
      short_trunc = ($urandom_range(0, 4) == 0);
      nw = short_trunc ? $urandom_range(0, needed - 1) : needed + $urandom_range(0, 2);
    end else begin
      nw = $urandom_range(0, 3);
    end
    while (bytes.size() < 4 * nw) bytes.push_back(8'($urandom));

    drive(1'b1, {vc, dt, len16[7:0], len16[15:8], 8'h5A}, err, cor);
    if (err) begin
      check("rand_hdr_err", pk(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, exp_vc, exp_dt), ALL_MASK);
    end else begin
      exp_vc = vc; exp_dt = dt;
      sp = (dt < 6'd4) ? (4'b1000 >> dt) : 4'b0000;
      check("rand_hdr", pk(0, 0, 0, 0, sp, 0, cor, 0, 0, 1, vc, dt), ALL_MASK);
    end
    for (int k = 1; k <= nw; k++) begin
      w = {bytes[4*k-4], bytes[4*k-3], bytes[4*k-2], bytes[4*k-1]};
      drive(1'b1, w, 1'($urandom), 1'($urandom));
      if (is_long && k <= needed) begin
        start = 4 * (k - 1);
        n  = (len > start) ? ((len - start > 4) ? 4 : len - start) : 0;
        m  = (n == 0) ? 32'h0 : (32'hFFFF_FFFF << (8 * (4 - n)));
        be = (n == 0) ? 4'h0 : (4'hF << (4 - n));
        check("rand_body", pk(w & m, be, n > 0, n > 0 && start + n == len, 0, 0, 0, 0,
                              CRC_ON && bad_crc && k == needed, 1, exp_vc, exp_dt), ALL_MASK);
      end else begin
        check("rand_discard", pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, exp_vc, exp_dt), ALL_MASK);
      end
    end
    drive(1'b0, 32'($urandom), 1'b0, 1'b0);
    check("rand_eot", pk(0, 0, 0, 0, 0, 0, 0, is_long && nw < needed, 0, 0, exp_vc, exp_dt),
          ALL_MASK);
    $display("burst %0d: hdr vc=%0d dt=%02h len=%0d err=%0b words=%0d crc_bad=%0b",
             idx, vc, dt, len, err, nw, bad_crc);
  endtask

  initial begin
    vec_t tbl[$];
    logic [7:0] q[$];
    logic [15:0] crc;
    tbl.push_back('{1, 32'h00000000, 0, 0, 32'h0, 4'h0, 0, 0, 4'b1000, 0, 0, 0, 1, 2'd0, 6'h00});
    tbl.push_back('{0, 32'h00000000, 0, 0, 32'h0, 4'h0, 0, 0, 4'b0000, 0, 0, 0, 0, 2'd0, 6'h00});
    tbl.push_back('{1, 32'h2A060000, 0, 1, 32'h0, 4'h0, 0, 0, 4'b0000, 0, 1, 0, 1, 2'd0, 6'h2A});
    tbl.push_back('{1, 32'h01020304, 0, 0, 32'h01020304, 4'hF, 1, 0, 4'b0000, 0, 0, 0, 1, 2'd0, 6'h2A});
    tbl.push_back('{1, 32'h0506CCCC, 0, 0, 32'h05060000, 4'hC, 1, 1, 4'b0000, 0, 0, 0, 1, 2'd0, 6'h2A});
    tbl.push_back('{1, 32'hDEADBEEF, 1, 0, 32'h0, 4'h0, 0, 0, 4'b0000, 0, 0, 0, 1, 2'd0, 6'h2A});
    tbl.push_back('{0, 32'h00000000, 0, 0, 32'h0, 4'h0, 0, 0, 4'b0000, 0, 0, 0, 0, 2'd0, 6'h2A});
    tbl.push_back('{1, 32'h24040000, 0, 0, 32'h0, 4'h0, 0, 0, 4'b0000, 0, 0, 0, 1, 2'd0, 6'h24});
    tbl.push_back('{1, 32'h11223344, 0, 0, 32'h11223344, 4'hF, 1, 1, 4'b0000, 0, 0, 0, 1, 2'd0, 6'h24});
    tbl.push_back('{1, 32'hAAAA0000, 0, 0, 32'h0, 4'h0, 0, 0, 4'b0000, 0, 0, 0, 1, 2'd0, 6'h24});
    tbl.push_back('{0, 32'h00000000, 0, 0, 32'h0, 4'h0, 0, 0, 4'b0000, 0, 0, 0, 0, 2'd0, 6'h24});
    tbl.push_back('{1, 32'h01000000, 1, 0, 32'h0, 4'h0, 0, 0, 4'b0000, 1, 0, 0, 1, 2'd0, 6'h24});
    tbl.push_back('{1, 32'h00000000, 0, 0, 32'h0, 4'h0, 0, 0, 4'b0000, 0, 0, 0, 1, 2'd0, 6'h24});
    tbl.push_back('{1, 32'h02000000, 0, 1, 32'h0, 4'h0, 0, 0, 4'b0000, 0, 0, 0, 1, 2'd0, 6'h24});
    tbl.push_back('{1, 32'h2A040000, 0, 0, 32'h0, 4'h0, 0, 0, 4'b0000, 0, 0, 0, 1, 2'd0, 6'h24});
    tbl.push_back('{0, 32'h00000000, 0, 0, 32'h0, 4'h0, 0, 0, 4'b0000, 0, 0, 0, 0, 2'd0, 6'h24});
    tbl.push_back('{1, 32'h02000000, 0, 1, 32'h0, 4'h0, 0, 0, 4'b0010, 0, 1, 0, 1, 2'd0, 6'h02});
    tbl.push_back('{0, 32'h00000000, 0, 0, 32'h0, 4'h0, 0, 0, 4'b0000, 0, 0, 0, 0, 2'd0, 6'h02});
    tbl.push_back('{1, 32'hC3000000, 0, 0, 32'h0, 4'h0, 0, 0, 4'b0001, 0, 0, 0, 1, 2'd3, 6'h03});
    tbl.push_back('{0, 32'h00000000, 0, 0, 32'h0, 4'h0, 0, 0, 4'b0000, 0, 0, 0, 0, 2'd3, 6'h03});
    tbl.push_back('{1, 32'h41000000, 0, 0, 32'h0, 4'h0, 0, 0, 4'b0100, 0, 0, 0, 1, 2'd1, 6'h01});
    tbl.push_back('{0, 32'h00000000, 0, 0, 32'h0, 4'h0, 0, 0, 4'b0000, 0, 0, 0, 0, 2'd1, 6'h01});
    tbl.push_back('{1, 32'h80000000, 1, 1, 32'h0, 4'h0, 0, 0, 4'b0000, 1, 0, 0, 1, 2'd1, 6'h01});
    tbl.push_back('{0, 32'h00000000, 0, 0, 32'h0, 4'h0, 0, 0, 4'b0000, 0, 0, 0, 0, 2'd1, 6'h01});
    tbl.push_back('{1, 32'h0C000000, 0, 0, 32'h0, 4'h0, 0, 0, 4'b0000, 0, 0, 0, 1, 2'd0, 6'h0C});
    tbl.push_back('{0, 32'h00000000, 0, 0, 32'h0, 4'h0, 0, 0, 4'b0000, 0, 0, 0, 0, 2'd0, 6'h0C});
    tbl.push_back('{1, 32'h6B000000, 0, 0, 32'h0, 4'h0, 0, 0, 4'b0000, 0, 0, 0, 1, 2'd1, 6'h2B});
    tbl.push_back('{1, 32'hFFFF1234, 0, 0, 32'h0, 4'h0, 0, 0, 4'b0000, 0, 0, 0, 1, 2'd1, 6'h2B});
    tbl.push_back('{1, 32'h12345678, 0, 0, 32'h0, 4'h0, 0, 0, 4'b0000, 0, 0, 0, 1, 2'd1, 6'h2B});
    tbl.push_back('{0, 32'h00000000, 0, 0, 32'h0, 4'h0, 0, 0, 4'b0000, 0, 0, 0, 0, 2'd1, 6'h2B});
    tbl.push_back('{1, 32'h2A100000, 0, 0, 32'h0, 4'h0, 0, 0, 4'b0000, 0, 0, 0, 1, 2'd0, 6'h2A});
    tbl.push_back('{1, 32'hA1A2A3A4, 0, 0, 32'hA1A2A3A4, 4'hF, 1, 0, 4'b0000, 0, 0, 0, 1, 2'd0, 6'h2A});
    tbl.push_back('{1, 32'hB1B2B3B4, 0, 0, 32'hB1B2B3B4, 4'hF, 1, 0, 4'b0000, 0, 0, 0, 1, 2'd0, 6'h2A});
    tbl.push_back('{0, 32'h00000000, 0, 0, 32'h0, 4'h0, 0, 0, 4'b0000, 0, 0, 1, 0, 2'd0, 6'h2A});
    tbl.push_back('{0, 32'h00000000, 0, 0, 32'h0, 4'h0, 0, 0, 4'b0000, 0, 0, 0, 0, 2'd0, 6'h2A});
    tbl.push_back('{1, 32'h1E030000, 0, 0, 32'h0, 4'h0, 0, 0, 4'b0000, 0, 0, 0, 1, 2'd0, 6'h1E});
    tbl.push_back('{1, 32'h01020304, 0, 0, 32'h01020300, 4'hE, 1, 1, 4'b0000, 0, 0, 0, 1, 2'd0, 6'h1E});
    tbl.push_back('{1, 32'h05000000, 0, 0, 32'h0, 4'h0, 0, 0, 4'b0000, 0, 0, 0, 1, 2'd0, 6'h1E});
    tbl.push_back('{0, 32'h00000000, 0, 0, 32'h0, 4'h0, 0, 0, 4'b0000, 0, 0, 0, 0, 2'd0, 6'h1E});
    tbl.push_back('{1, 32'h24040000, 0, 0, 32'h0, 4'h0, 0, 0, 4'b0000, 0, 0, 0, 1, 2'd0, 6'h24});
    tbl.push_back('{1, 32'h11223344, 0, 0, 32'h11223344, 4'hF, 1, 1, 4'b0000, 0, 0, 0, 1, 2'd0, 6'h24});
    tbl.push_back('{0, 32'h00000000, 0, 0, 32'h0, 4'h0, 0, 0, 4'b0000, 0, 0, 1, 0, 2'd0, 6'h24});
    tbl.push_back('{0, 32'h00000000, 0, 0, 32'h0, 4'h0, 0, 0, 4'b0000, 0, 0, 0, 0, 2'd0, 6'h24});

    repeat (3) @(posedge clk);
    #1;
    check("reset_state", pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 6'h00), ALL_MASK);
    rst = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].e, tbl[i].c);
      check($sformatf("vec%0d", i), pk(tbl[i].pd, tbl[i].be, tbl[i].pv, tbl[i].last, tbl[i].sp,
            tbl[i].herr, tbl[i].cerr, tbl[i].tr, 1'b0, tbl[i].busy, tbl[i].vc, tbl[i].dt),
            TBL_MASK);
      $display("vec %0d: valid=%0b data=%08h", i, tbl[i].v, tbl[i].d);
    end

    // Reset in the middle of a long payload: outputs clear at once, no truncation reported.
    drive(1'b1, 32'h2A100000, 1'b0, 1'b0);
    drive(1'b1, 32'hC1C2C3C4, 1'b0, 1'b0);
    check("pre_rst_payload", pk(32'hC1C2C3C4, 4'hF, 1, 0, 0, 0, 0, 0, 0, 1, 2'd0, 6'h2A), ALL_MASK);
    rst = 1'b1;
    #1;
    check("rst_async", pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 6'h00), ALL_MASK);
    drive(1'b1, 32'hFFFFFFFF, 1'b0, 1'b0);
    check("rst_hold", pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 6'h00), ALL_MASK);
    rst = 1'b0;
    drive(1'b1, 32'h01000000, 1'b0, 1'b0);
    check("rst_first_hdr", pk(0, 0, 0, 0, 4'b0100, 0, 0, 0, 0, 1, 2'd0, 6'h01), ALL_MASK);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    check("rst_idle", pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 6'h01), ALL_MASK);
    $display("reset sequence done");

    // Footer check on payload 00 01 02 03, first with a good footer then one flipped bit.
    q = '{8'h00, 8'h01, 8'h02, 8'h03};
    crc = crc16(q);
    for (int flip = 0; flip < 2; flip++) begin
      drive(1'b1, 32'h2A040000, 1'b0, 1'b0);
      drive(1'b1, 32'h00010203, 1'b0, 1'b0);
      check("crc_payload", pk(32'h00010203, 4'hF, 1, 1, 0, 0, 0, 0, 0, 1, 2'd0, 6'h2A), ALL_MASK);
      drive(1'b1, {crc[7:0] ^ 8'(flip), crc[15:8], 16'h0000}, 1'b0, 1'b0);
      check($sformatf("crc_footer_flip%0d", flip),
            pk(0, 0, 0, 0, 0, 0, 0, 0, CRC_ON && flip == 1, 1, 2'd0, 6'h2A), ALL_MASK);
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      $display("crc sequence flip=%0d footer=%04h", flip, crc);
    end
    exp_vc = 2'd0;
    exp_dt = 6'h2A;

    for (int b = 0; b < 200; b++) run_random(b);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
